// File: rtl/text_stream_writer_pkg.sv
// text_stream_writer_pkg
//   Shared constants for the text stream writer: a ceil-log2 helper for
//   port/counter widths, the control-code byte values and the FSM state
//   encoding.
package text_stream_writer_pkg;

  // Bits needed to index n items (minimum 1).
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 1;
    while (r < 31 && (32'd1 << r) < n) r++;
    return r;
  endfunction

  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_TAB      = 8'h09;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_CLEAR_LINE = 2'd1;
  localparam logic [1:0] S_CLEAR_ALL  = 2'd2;
  localparam logic [1:0] S_TAB        = 2'd3;

endpackage

// File: rtl/text_stream_writer_cursor_counter.sv
// text_stream_writer_cursor_counter
//   2-D column/row counter used both for the text cursor and for the clear
//   sweeps. Column wraps at width-1 into the next row; row wraps at height-1
//   back to 0. Compares are explicit, so non-power-of-two sizes are fine.
// Ports:
//   clk, reset      clock, async active-low reset (counter -> (0,0))
//   zero            load (0,0)                       (highest priority)
//   nl              x=0, y=y+1 mod height
//   cr              x=0
//   back            x=x-1 when x>0, never leaves the row
//   adv             x=x+1, wrapping into the next row (lowest priority)
//   x, y            current position
//   x_last, y_last  position is on the last column / last row
module text_stream_writer_cursor_counter
  import text_stream_writer_pkg::*;
#(
  parameter int unsigned width  = 128,
  parameter int unsigned height = 48,
  parameter int unsigned XW     = log2(width),
  parameter int unsigned YW     = log2(height)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          zero,
  input  logic          nl,
  input  logic          cr,
  input  logic          back,
  input  logic          adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          x_last,
  output logic          y_last
);

  assign x_last = (x == XW'(width - 1));
  assign y_last = (y == YW'(height - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (zero) begin
      x <= '0;
      y <= '0;
    end else if (nl || (adv && x_last)) begin
      x <= '0;
      y <= y_last ? '0 : y + 1'b1;
    end else if (cr) begin
      x <= '0;
    end else if (back) begin
      if (x != '0) x <= x - 1'b1;
    end else if (adv) begin
      x <= x + 1'b1;
    end
  end

endmodule

// File: rtl/text_stream_writer.sv
// text_stream_writer
//   Turns a byte stream (ASCII + control codes) into screen-buffer writes
//   and tracks the text cursor. Printables write at the cursor (1 byte/cycle);
//   LF/line wrap clear the new row, FF clears the screen; both stall input.
//   refresh commits a frame on frame_start, deferred past any in-flight
//   clear so a half-cleared screen is never shown.
// Build option: TEXT_TAB_EXPAND_EN -- expand 0x09 to spaces up to the next
//   multiple-of-8 column; otherwise 0x09 is ignored.
// Ports:
//   clk, reset           clock, async active-low reset
//   char_valid/char_in   byte source; char_ready accepts it (IDLE only)
//   frame_start          vertical-blank pulse
//   write_en,x_w,y_w,c_out  screen buffer write port (registered)
//   refresh              one-cycle frame commit
//   cursor_x, cursor_y   cursor position for the overlay
module text_stream_writer
  import text_stream_writer_pkg::*;
#(
  parameter int unsigned width      = 128,
  parameter int unsigned height     = 48,
  parameter int unsigned char_width = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    char_valid,
  input  logic [char_width-1:0]   char_in,
  output logic                    char_ready,
  input  logic                    frame_start,
  output logic                    write_en,
  output logic [log2(width)-1:0]  x_w,
  output logic [log2(height)-1:0] y_w,
  output logic [char_width-1:0]   c_out,
  output logic                    refresh,
  output logic [log2(width)-1:0]  cursor_x,
  output logic [log2(height)-1:0] cursor_y
);

  localparam int unsigned XW = log2(width);
  localparam int unsigned YW = log2(height);

  logic [1:0]            state, nxt;
  logic                  pend;
  logic                  accept, printable;
  logic                  c_zero, c_nl, c_cr, c_back, c_adv;
  logic                  s_zero, s_adv;
  logic                  wr;
  logic [XW-1:0]         wx;
  logic [YW-1:0]         wy;
  logic [char_width-1:0] wc;
  logic                  cur_x_last, cur_y_last_unused;
  logic [XW-1:0]         sw_x;
  logic [YW-1:0]         sw_y;
  logic                  sw_x_last, sw_y_last;

  text_stream_writer_cursor_counter #(.width(width), .height(height)) u_cursor (
    .clk(clk), .reset(reset), .zero(c_zero), .nl(c_nl), .cr(c_cr),
    .back(c_back), .adv(c_adv), .x(cursor_x), .y(cursor_y),
    .x_last(cur_x_last), .y_last(cur_y_last_unused)
  );

  // Sweep position for CLEAR_LINE (x only, row = cursor row) and CLEAR_ALL.
  text_stream_writer_cursor_counter #(.width(width), .height(height)) u_sweep (
    .clk(clk), .reset(reset), .zero(s_zero), .nl(1'b0), .cr(1'b0),
    .back(1'b0), .adv(s_adv), .x(sw_x), .y(sw_y),
    .x_last(sw_x_last), .y_last(sw_y_last)
  );

  assign accept    = char_valid & char_ready;
  assign printable = (char_in >= char_width'(CH_SPACE)) &&
                     (char_in <= char_width'(CH_PRINT_HI));

`ifdef TEXT_TAB_EXPAND_EN
  logic tab_last;  // cursor sits on the column just before a tab stop
  assign tab_last = (32'(cursor_x) & 32'd7) == 32'd7;
`endif

  always_comb begin
    nxt    = state;
    c_zero = 1'b0; c_nl = 1'b0; c_cr = 1'b0; c_back = 1'b0; c_adv = 1'b0;
    s_zero = 1'b0; s_adv = 1'b0;
    wr     = 1'b0;
    wx     = cursor_x;
    wy     = cursor_y;
    wc     = char_width'(CH_SPACE);
    case (state)
      S_IDLE: if (accept) begin
        if (printable) begin
          wr = 1'b1; wc = char_in; c_adv = 1'b1;
          if (cur_x_last) begin nxt = S_CLEAR_LINE; s_zero = 1'b1; end
        end else if (char_in == char_width'(CH_LF)) begin
          c_nl = 1'b1; nxt = S_CLEAR_LINE; s_zero = 1'b1;
        end else if (char_in == char_width'(CH_CR)) begin
          c_cr = 1'b1;
        end else if (char_in == char_width'(CH_BS)) begin
          if (cursor_x != '0) begin
            c_back = 1'b1; wr = 1'b1; wx = cursor_x - 1'b1;
          end
        end else if (char_in == char_width'(CH_FF)) begin
          c_zero = 1'b1; s_zero = 1'b1; nxt = S_CLEAR_ALL;
`ifdef TEXT_TAB_EXPAND_EN
        end else if (char_in == char_width'(CH_TAB)) begin
          // First space goes out on acceptance, like a printable.
          wr = 1'b1; c_adv = 1'b1;
          if (cur_x_last)    begin nxt = S_CLEAR_LINE; s_zero = 1'b1; end
          else if (!tab_last) nxt = S_TAB;
`endif
        end
      end
      S_CLEAR_LINE: begin
        wr = 1'b1; wx = sw_x; s_adv = 1'b1;
        if (sw_x_last) nxt = S_IDLE;
      end
      S_CLEAR_ALL: begin
        wr = 1'b1; wx = sw_x; wy = sw_y; s_adv = 1'b1;
        if (sw_x_last && sw_y_last) nxt = S_IDLE;
      end
`ifdef TEXT_TAB_EXPAND_EN
      S_TAB: begin
        wr = 1'b1; c_adv = 1'b1;
        if (cur_x_last)    begin nxt = S_CLEAR_LINE; s_zero = 1'b1; end
        else if (tab_last) nxt = S_IDLE;
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_CLEAR_ALL;  // full clear runs right after release
      char_ready <= 1'b0;
      write_en   <= 1'b0;
      x_w        <= '0;
      y_w        <= '0;
      c_out      <= '0;
      refresh    <= 1'b0;
      pend       <= 1'b0;
    end else begin
      state      <= nxt;
      char_ready <= (nxt == S_IDLE);
      write_en   <= wr;
      if (wr) begin
        x_w   <= wx;
        y_w   <= wy;
        c_out <= wc;
      end
      // frame_start while busy is held until back in IDLE; repeats collapse.
      refresh <= (state == S_IDLE) & (frame_start | pend);
      pend    <= (state != S_IDLE) & (frame_start | pend);
    end
  end

endmodule

// File: tb/tb_text_stream_writer.sv
module tb_text_stream_writer;
  localparam int W = 8;
  localparam int H = 4;
  localparam logic [7:0] BS = 8'h08, TAB = 8'h09, LF = 8'h0A, FF = 8'h0C, CR = 8'h0D;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       frame_start = 1'b0;
  logic       char_ready, write_en, refresh;
  logic [2:0] x_w, cursor_x;
  logic [1:0] y_w, cursor_y;
  logic [7:0] c_out;

  text_stream_writer #(.width(W), .height(H), .char_width(8)) dut (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char_in(char_in),
    .char_ready(char_ready), .frame_start(frame_start), .write_en(write_en),
    .x_w(x_w), .y_w(y_w), .c_out(c_out), .refresh(refresh),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: screen semantics as a list of expected writes.
  int exp_q[$];
  int mx = 0, my = 0;

  function automatic int pk(input int x, input int y, input int c);
    return (c << 16) | (y << 8) | x;
  endfunction

  task automatic clear_row(input int y);
    for (int x = 0; x < W; x++) exp_q.push_back(pk(x, y, 32));
  endtask

  task automatic clear_all();
    for (int y = 0; y < H; y++) clear_row(y);
  endtask

  task automatic newline();
    mx = 0; my = (my + 1) % H; clear_row(my);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back(pk(mx, my, int'(b)));
      mx++;
      if (mx == W) newline();
    end else if (b == LF) newline();
    else if (b == CR) mx = 0;
    else if (b == BS) begin
      if (mx > 0) begin mx--; exp_q.push_back(pk(mx, my, 32)); end
    end else if (b == FF) begin
      mx = 0; my = 0; clear_all();
    end
`ifdef TEXT_TAB_EXPAND_EN
    else if (b == TAB) begin
      do begin exp_q.push_back(pk(mx, my, 32)); mx++; end while (mx % 8 != 0 && mx < W);
      if (mx >= W) newline();
    end
`endif
  endtask

  // Every write the DUT issues must be the next one the model expects.
  always @(negedge clk) begin
    if (write_en) begin
      if (exp_q.size() == 0) chk("write_extra", pk(int'(x_w), int'(y_w), int'(c_out)), -1);
      else chk("write", pk(int'(x_w), int'(y_w), int'(c_out)), exp_q.pop_front());
    end
  end

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (!char_ready && n < bound) begin @(negedge clk); n++; end
    if (!char_ready) chk("ready_timeout", 0, 1);
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic [7:0] b);
    int n;
    wait_ready(200, n);
    chk("cursor_x", int'(cursor_x), mx);
    chk("cursor_y", int'(cursor_y), my);
    char_valid = 1'b1; char_in = b;
    model_byte(b);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nref;
    logic [7:0] b;
    #1 reset = 1'b0;
    #2;
    chk("rst_char_ready", int'(char_ready), 0);
    chk("rst_write_en", int'(write_en), 0);
    chk("rst_x_w", int'(x_w), 0);
    chk("rst_y_w", int'(y_w), 0);
    chk("rst_c_out", int'(c_out), 0);
    chk("rst_refresh", int'(refresh), 0);
    chk("rst_cursor", int'({cursor_y, cursor_x}), 0);

    // Power-up clear: 32 space writes, ready alongside the last one.
    clear_all();
    @(negedge clk); #2 reset = 1'b1;
    wait_ready(200, n);
    chk("init_clear_cycles", n, W * H);
    chk("init_cursor", int'({cursor_y, cursor_x}), 0);

    // Back-to-back printables, latency 1, no stall.
    send(8'h41);
    chk("lat_A_we", int'(write_en), 1);
    chk("lat_A_c", int'(c_out), 8'h41);
    send(8'h42);
    chk("lat_B_we", int'(write_en), 1);
    chk("lat_B_x", int'(x_w), 1);
    chk("ab_ready", int'(char_ready), 1);
    chk("ab_cursor_x", int'(cursor_x), 2);

    // Line wrap on the bottom row goes to row 0 and clears it.
    send(CR); send(LF); send(LF); send(LF);
    for (int i = 0; i < W; i++) send(8'(8'h30 + i));
    chk("wrap_last_x", int'(x_w), W - 1);
    chk("wrap_last_y", int'(y_w), H - 1);
    n = 0;
    while (!char_ready && n < 100) begin n++; @(negedge clk); end
    chk("wrap_ready_low", n, W);
    chk("wrap_cursor", int'({cursor_y, cursor_x}), 0);

    // Backspace at column 0 is a no-op; otherwise erases the previous cell.
    send(LF);
    send(BS);
    chk("bs0_we", int'(write_en), 0);
    send(8'h58); send(8'h59); send(8'h5A);
    send(BS);
    chk("bs_we", int'(write_en), 1);
    chk("bs_x", int'(x_w), 2);
    chk("bs_y", int'(y_w), 1);
    chk("bs_c", int'(c_out), 8'h20);
    chk("bs_cursor_x", int'(cursor_x), 2);

    // refresh in IDLE: one cycle, the cycle after frame_start.
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    chk("idle_refresh", int'(refresh), 1);
    @(negedge clk);
    chk("idle_refresh_end", int'(refresh), 0);

    // frame_start together with an accepted byte: both take effect.
    frame_start = 1'b1;
    send(8'h51);
    frame_start = 1'b0;
    chk("coinc_refresh", int'(refresh), 1);
    chk("coinc_c", int'(c_out), 8'h51);

    // frame_start during a form-feed clear: deferred, collapsed to one pulse.
    send(FF);
    repeat (5) @(negedge clk);
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    repeat (3) @(negedge clk);
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    n = 0; nref = 0;
    while (!char_ready && n < 200) begin @(negedge clk); n++; if (refresh) nref++; end
    chk("ff_no_refresh", nref, 0);
    chk("ff_last_write", int'(write_en), 1);
    @(negedge clk);
    chk("ff_refresh", int'(refresh), 1);
    @(negedge clk);
    chk("ff_refresh_end", int'(refresh), 0);

    // Reset in the middle of a clear.
    send(8'h4B);
    send(FF);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    exp_q.delete(); mx = 0; my = 0; clear_all();
    #1;
    chk("mid_rst_we", int'(write_en), 0);
    chk("mid_rst_ready", int'(char_ready), 0);
    chk("mid_rst_cursor", int'({cursor_y, cursor_x}), 0);
    @(negedge clk); #2 reset = 1'b1;
    wait_ready(200, n);
    chk("mid_rst_clear_cycles", n, W * H);

`ifdef TEXT_TAB_EXPAND_EN
    send(8'h61); send(8'h62); send(8'h63);
    send(TAB);
    wait_ready(200, n);
    chk("tab_cursor", int'({cursor_y, cursor_x}), int'({2'd1, 3'd0}));
`endif

    // Randomized byte stream against the model.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 68) b = 8'($urandom_range(32, 126));
      else if (r < 76) b = LF;
      else if (r < 81) b = CR;
      else if (r < 89) b = BS;
      else if (r < 91) b = FF;
      else if (r < 94) b = TAB;
      else b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(b);
    end
    wait_ready(200, n);
    repeat (5) @(negedge clk);
    chk("final_cursor_x", int'(cursor_x), mx);
    chk("final_cursor_y", int'(cursor_y), my);
    chk("pending_writes", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/text_stream_writer.md
Name: text_stream_writer

Overview:
- Upstream feeder for the screen buffer: accepts a byte stream of ASCII characters and control codes, and tracks a text cursor.
- Turns that stream into the buffer's write port (write_en, x_w, y_w, c_in) plus its frame-commit pulse (refresh).
- Handles line wrap, newline, carriage return, backspace and form-feed clear; multi-cycle clears stall the input via a valid/ready handshake.
- Sits between the host/UART byte source and the screen buffer in the XGA text path.

Parameters:
- width, 128, columns per screen (1024 px / 8-px glyph)
- height, 48, rows per screen (768 px / 16-px glyph)
- char_width, 8, bits per stored character code

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- char_valid  in  1  byte-source strobe.
- char_in  in  char_width  byte from source.
- char_ready  out  1  writer can accept char_in this cycle.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- write_en  out  1  to screen buffer write_en.
- x_w  out  log2(width)  to screen buffer x_w.
- y_w  out  log2(height)  to screen buffer y_w.
- c_out  out  char_width  to screen buffer c_in.
- refresh  out  1  to screen buffer refresh (commit frame).
- cursor_x  out  log2(width)  current cursor column, for cursor overlay.
- cursor_y  out  log2(height)  current cursor row.

Behaviour:
- Reset values: char_ready=0, write_en=0, x_w=0, y_w=0, c_out=0, refresh=0, cursor=(0,0).
- After reset release the FSM enters CLEAR_ALL.
- All outputs are registered. Transfer occurs on char_valid & char_ready. The write for a byte appears on the cycle after acceptance (latency 1).
- FSM states: IDLE, CLEAR_LINE, CLEAR_ALL.
- In IDLE, char_ready=1. char_ready=0 in CLEAR_LINE and CLEAR_ALL.
- Printable byte (0x20..0x7E):
  - Write at the cursor; cursor_x+1.
  - If cursor_x was width-1: cursor_x=0, cursor_y=(cursor_y+1) mod height, then CLEAR_LINE on the new row.
  - Otherwise stay in IDLE, giving 1 byte/cycle throughput.
- 0x0A newline: cursor_x=0, cursor_y=(cursor_y+1) mod height, CLEAR_LINE; no write for the byte itself.
- 0x0D carriage return: cursor_x=0, no write, stay IDLE.
- 0x08 backspace:
  - If cursor_x>0: cursor_x-1 and write 0x20 at the new position.
  - At cursor_x=0: no-op (never moves up a row).
- 0x0C form feed: CLEAR_ALL, cursor=(0,0).
- Any other byte: accepted and discarded, no write, no state change.
- CLEAR_LINE: writes 0x20 to columns 0..width-1 of cursor_y, one per cycle (width cycles), then IDLE.
- CLEAR_ALL: writes 0x20 to every cell in row-major order (width*height cycles), then IDLE with cursor=(0,0).
- Bottom-row wrap goes to row 0 (no scroll); the cleared row gives the appearance of a fresh line.
- refresh:
  - On frame_start while in IDLE, refresh=1 for exactly one cycle (the next cycle).
  - On frame_start while clearing, the pulse is deferred until the cycle after the clear finishes, so a partial clear is never committed.
  - Multiple deferred frame_starts collapse to one pulse.
- frame_start coincident with an accepted byte: both proceed. refresh pulses, and the byte's write is issued in the same cycle.
- Reset asserted mid-clear: immediate return to reset values; a full CLEAR_ALL restarts after release.
- Column/row counters compare against width-1 / height-1 explicitly; non-power-of-two sizes must wrap correctly.

Optional Feature:
- Macro: TEXT_TAB_EXPAND_EN.
- Defined: 0x09 is expanded.
  - Enter TAB state, char_ready=0.
  - Write 0x20 one per cycle until cursor_x reaches the next multiple of 8.
  - If that multiple reaches or exceeds width, wrap as for a printable byte at width-1 (newline + CLEAR_LINE).
- Undefined: 0x09 is treated as an ignored control code.

Decomposition:
- Shared package const_funcs.h: log2 function, control-code constants (CH_BS=0x08, CH_TAB=0x09, CH_LF=0x0A, CH_FF=0x0C, CH_CR=0x0D, CH_SPACE=0x20), and the FSM state encoding.
- One natural sub-module: cursor_counter, a 2-D column/row counter with advance, carriage-return, back, load-zero and wrap flags. It is shared by cursor tracking and the clear sweeps.

Test Plan (width=8, height=4 for simulation):
- Release reset, then wait: 32 writes of 0x20 covering (0,0)..(7,3); char_ready rises on cycle 33; cursor=(0,0).
- Send "AB" back-to-back: writes ('A',0,0) and ('B',1,0) on consecutive cycles; char_ready stays 1; cursor=(2,0).
- Send 8 printable bytes from (0,3): final write at (7,3); cursor=(0,0); 8 space writes on row 0; char_ready low for 8 cycles.
- Sequence:
  - Send 0x08 at (0,1): no write, cursor unchanged.
  - Send 0x08 at (3,1): write (0x20,2,1), cursor=(2,1).
- Pulse frame_start 5 cycles into a form-feed clear: no refresh during the clear; refresh=1 exactly one cycle after the last clear write.
- With TEXT_TAB_EXPAND_EN, send 0x09 at (3,0): spaces written at columns 3..7; cursor=(0,1); row 1 cleared.
